letter_scroll_ctrl: RTL and testbench
=====================================

Name: letter_scroll_ctrl

Overview:
- Sequences the 5-bit letter-code seven-segment decoder across a multiplexed bank of digits.
- Holds a small message buffer loaded by the host.
- Time-multiplexes one letter code per digit, with a one-hot active-low digit select.
- Scrolls the message left at a programmable rate when it is longer than the display.
- Sits between the host/control FSM and the letter decoder plus digit drivers.

Parameters:
NUM_DIGITS, 4, number of multiplexed display digits (2..8)
MAX_LEN, 16, message buffer depth in letters (power of 2)
MUX_DIV, 50000, clk cycles each digit stays selected (>=2)
SCROLL_DIV, 25, full mux frames per one-letter scroll step (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: latch msg_len, begin display
stop  in  1  one-cycle pulse: end display, return to idle
wr_en  in  1  write message buffer
wr_addr  in  log2(MAX_LEN)  buffer write address
wr_data  in  5  letter code to write
msg_len  in  log2(MAX_LEN)+1  message length, valid 1..MAX_LEN
letter  out  5  letter code to decoder; 31 = blank
digit_sel_n  out  NUM_DIGITS  active-low one-hot digit enable; bit 0 = leftmost digit
busy  out  1  high in RUN
wrap  out  1  one-cycle pulse when scroll offset returns to 0

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; letter=31; digit_sel_n all 1; busy=0; wrap=0.
  - All buffer entries = 31; counters, offset and latched length = 0.
- Buffer:
  - Registered write on clk when wr_en=1, in any state.
  - A write is visible on the next read of that entry.
  - No read-during-write bypass.
- FSM IDLE:
  - start with 1<=msg_len<=MAX_LEN: latch len, clear mux counter, digit index, frame counter and offset. Next cycle is RUN.
  - start with msg_len=0 or msg_len>MAX_LEN is ignored; remain IDLE.
- FSM RUN:
  - busy=1.
  - Mux counter counts 0..MUX_DIV-1. At terminal count, digit index advances (NUM_DIGITS-1 wraps to 0).
  - When the digit index wraps, frame counter counts 0..SCROLL_DIV-1. At its terminal, offset advances.
- Scrolling (only when len > NUM_DIGITS):
  - offset = (offset+1) mod len.
  - wrap=1 for exactly the cycle in which offset becomes 0 from len-1.
- Static display (len <= NUM_DIGITS):
  - offset stays 0; wrap never asserts.
  - Digit positions >= len show 31.
- Output mapping:
  - Digit i shows buf[(offset+i) mod len].
  - letter and digit_sel_n are registered together from the same index/offset. They change on the same edge; no glitch combination is ever presented.
  - First RUN cycle: digit_sel_n has bit 0 low, letter=buf[0].
- stop:
  - stop in RUN: next cycle IDLE, letter=31, digit_sel_n all 1, busy=0.
  - stop in IDLE: no effect.
  - start and stop in the same cycle: stop wins.
  - start in RUN: ignored; msg_len is not relatched.
- msg_len changes during RUN: ignored.
- Reset mid-RUN: immediate return to reset values. Buffer contents are lost (re-initialised to 31).
- The output path never emits codes 16..30.
- Host-written codes pass through unmodified, apart from the blank insertion rules above.

Test Plan:
(Bench parameters: NUM_DIGITS=4, MAX_LEN=16, MUX_DIV=4, SCROLL_DIV=2.)
- Reset release: check letter=31, digit_sel_n=4'b1111, busy=0 -> then write buf[0..5]=0,1,2,3,4,5, msg_len=6, pulse start -> next cycle busy=1, digit_sel_n=4'b1110, letter=0.
- Mux cadence (same load) -> digit_sel_n steps 1110, 1101, 1011, 0111 every 4 clks with letter 0,1,2,3; after 16 clks returns to 1110/letter 0.
- Scroll: after 32 clks in RUN -> digit 0 shows letter 1 (offset=1); after 6 steps (192 clks) wrap pulses exactly 1 cycle and digit 0 shows 0 again.
- Short message: msg_len=2, buf=7,9 -> digits show 7, 9, 31, 31 repeatedly; offset fixed; wrap never asserts over 500 clks.
- Control corners: start with msg_len=0 -> stays IDLE; start+stop same cycle in RUN -> IDLE; start during RUN with different msg_len -> sequence unchanged; write buf[1]=12 during RUN -> next selection of that entry shows 12.
- Async reset: assert rst_n=0 mid-digit (not on an edge) -> outputs go to reset values immediately; after release, start with msg_len=6 shows letter 31 on all digits (buffer cleared).

Source files
------------

// File: rtl/letter_scroll_if.sv
// Host/decoder-side bundle for letter_scroll_ctrl: message load, run control
// and the multiplexed letter/digit outputs.
interface letter_scroll_if #(
    parameter int NUM_DIGITS = 4,
    parameter int MAX_LEN    = 16
);
    localparam int AW = $clog2(MAX_LEN);

    logic                  start;
    logic                  stop;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [4:0]            wr_data;
    logic [AW:0]           msg_len;
    logic [4:0]            letter;
    logic [NUM_DIGITS-1:0] digit_sel_n;
    logic                  busy;
    logic                  wrap;

    modport master (
        output start, stop, wr_en, wr_addr, wr_data, msg_len,
        input  letter, digit_sel_n, busy, wrap
    );

    modport slave (
        input  start, stop, wr_en, wr_addr, wr_data, msg_len,
        output letter, digit_sel_n, busy, wrap
    );
endinterface

// File: rtl/letter_scroll_ctrl.sv
// Letter scroll controller: holds a host-loaded message, time-multiplexes one
// letter code per digit and scrolls the message left when it is longer than
// the display. letter and digit_sel_n come from one register stage fed by the
// same next-state index/offset, so they always change together.
module letter_scroll_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int MAX_LEN    = 16,
    parameter int MUX_DIV    = 50000,
    parameter int SCROLL_DIV = 25
) (
    input  logic          clk,
    input  logic          rst_n,
    letter_scroll_if.slave bus
);
    localparam int AW = $clog2(MAX_LEN);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int MW = $clog2(MUX_DIV);
    localparam int FW = $clog2(SCROLL_DIV + 1);

    localparam logic [0:0]            ST_IDLE   = 1'b0;
    localparam logic [0:0]            ST_RUN    = 1'b1;
    localparam logic [4:0]            BLANK     = 5'd31;
    localparam logic [MW-1:0]         MUX_TC    = MW'(MUX_DIV - 1);
    localparam logic [MW-1:0]         MUX_ONE   = MW'(1);
    localparam logic [IW-1:0]         IDX_TC    = IW'(NUM_DIGITS - 1);
    localparam logic [IW-1:0]         IDX_ONE   = IW'(1);
    localparam logic [FW-1:0]         FRAME_TC  = FW'(SCROLL_DIV - 1);
    localparam logic [FW-1:0]         FRAME_ONE = FW'(1);
    localparam logic [AW-1:0]         OFF_ONE   = AW'(1);
    localparam logic [AW:0]           LEN_ZERO  = (AW+1)'(0);
    localparam logic [AW:0]           LEN_ONE   = (AW+1)'(1);
    localparam logic [AW:0]           LEN_MAX   = (AW+1)'(MAX_LEN);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE   = NUM_DIGITS'(1);

    // Codes 16..30 have no glyph; the decoder only ever sees 0..15 or blank.
    function automatic logic [4:0] sanitize_code(input logic [4:0] code);
        logic [4:0] res;
        if (code[4]) begin
            res = BLANK;
        end else begin
            res = code;
        end
        return res;
    endfunction

    logic [0:0]            state_r, state_nxt_s;
    logic [AW:0]           len_r, len_nxt_s;
    logic [MW-1:0]         mux_cnt_r, mux_nxt_s;
    logic [IW-1:0]         idx_r, idx_nxt_s;
    logic [FW-1:0]         frame_r, frame_nxt_s;
    logic [AW-1:0]         off_r, off_nxt_s;
    logic                  wrap_nxt_s;
    logic                  start_ok_s;
    logic [4:0]            msg_buf_r [MAX_LEN];
    logic [AW:0]           pos_s;
    logic [AW-1:0]         rd_idx_s;
    logic [4:0]            letter_nxt_s, letter_r;
    logic [NUM_DIGITS-1:0] sel_nxt_s, sel_r;
    logic                  busy_nxt_s, busy_r, wrap_r;

    // Next-state logic for the run FSM and its mux/frame/offset counters.
    always_comb begin
        state_nxt_s = state_r;
        len_nxt_s   = len_r;
        mux_nxt_s   = mux_cnt_r;
        idx_nxt_s   = idx_r;
        frame_nxt_s = frame_r;
        off_nxt_s   = off_r;
        wrap_nxt_s  = 1'b0;
        start_ok_s  = bus.start && (bus.msg_len != LEN_ZERO) && (bus.msg_len <= LEN_MAX);
        case (state_r)
            ST_IDLE: begin
                if (bus.stop) begin
                    state_nxt_s = ST_IDLE;
                end else if (start_ok_s) begin
                    state_nxt_s = ST_RUN;
                    len_nxt_s   = bus.msg_len;
                    mux_nxt_s   = '0;
                    idx_nxt_s   = '0;
                    frame_nxt_s = '0;
                    off_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    state_nxt_s = ST_IDLE;
                end else if (mux_cnt_r != MUX_TC) begin
                    mux_nxt_s = mux_cnt_r + MUX_ONE;
                end else begin
                    mux_nxt_s = '0;
                    if (idx_r != IDX_TC) begin
                        idx_nxt_s = idx_r + IDX_ONE;
                    end else begin
                        idx_nxt_s = '0;
                        if (frame_r != FRAME_TC) begin
                            frame_nxt_s = frame_r + FRAME_ONE;
                        end else begin
                            frame_nxt_s = '0;
                            // Messages that fit the display never scroll.
                            if (32'(len_r) <= 32'(NUM_DIGITS)) begin
                                off_nxt_s = '0;
                            end else if ({1'b0, off_r} == (len_r - LEN_ONE)) begin
                                off_nxt_s  = '0;
                                wrap_nxt_s = 1'b1;
                            end else begin
                                off_nxt_s = off_r + OFF_ONE;
                            end
                        end
                    end
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output selection from the next index/offset: (offset+i) mod len, blank past len.
    always_comb begin
        pos_s = {1'b0, off_nxt_s} + (AW+1)'(idx_nxt_s);
        if (pos_s >= len_nxt_s) begin
            rd_idx_s = AW'(pos_s - len_nxt_s);
        end else begin
            rd_idx_s = AW'(pos_s);
        end
        if (state_nxt_s == ST_RUN) begin
            busy_nxt_s = 1'b1;
            sel_nxt_s  = ~(SEL_ONE << idx_nxt_s);
            if (32'(idx_nxt_s) >= 32'(len_nxt_s)) begin
                letter_nxt_s = BLANK;
            end else begin
                letter_nxt_s = sanitize_code(msg_buf_r[rd_idx_s]);
            end
        end else begin
            busy_nxt_s   = 1'b0;
            sel_nxt_s    = '1;
            letter_nxt_s = BLANK;
        end
    end

    // FSM state, latched length and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            len_r     <= '0;
            mux_cnt_r <= '0;
            idx_r     <= '0;
            frame_r   <= '0;
            off_r     <= '0;
        end else begin
            state_r   <= state_nxt_s;
            len_r     <= len_nxt_s;
            mux_cnt_r <= mux_nxt_s;
            idx_r     <= idx_nxt_s;
            frame_r   <= frame_nxt_s;
            off_r     <= off_nxt_s;
        end
    end

    // Message buffer: host writes in any state; reads see the pre-write value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                msg_buf_r[i] <= BLANK;
            end
        end else if (bus.wr_en) begin
            msg_buf_r[bus.wr_addr] <= bus.wr_data;
        end else begin
            msg_buf_r <= msg_buf_r;
        end
    end

    // Output registers: letter, digit select, busy and wrap update on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            letter_r <= BLANK;
            sel_r    <= '1;
            busy_r   <= 1'b0;
            wrap_r   <= 1'b0;
        end else begin
            letter_r <= letter_nxt_s;
            sel_r    <= sel_nxt_s;
            busy_r   <= busy_nxt_s;
            wrap_r   <= wrap_nxt_s;
        end
    end

    assign bus.letter      = letter_r;
    assign bus.digit_sel_n = sel_r;
    assign bus.busy        = busy_r;
    assign bus.wrap        = wrap_r;

endmodule

// File: tb/tb_letter_scroll_ctrl.sv
// Self-checking bench for letter_scroll_ctrl (4 digits, 16-letter buffer,
// 4 clks per digit, 2 frames per scroll step).
module tb_letter_scroll_ctrl;
    localparam int ND = 4;
    localparam int ML = 16;
    localparam int MD = 4;
    localparam int SD = 2;

    logic clk;
    logic rst_n;

    letter_scroll_if #(.NUM_DIGITS(ND), .MAX_LEN(ML)) bif ();

    letter_scroll_ctrl #(
        .NUM_DIGITS(ND), .MAX_LEN(ML), .MUX_DIV(MD), .SCROLL_DIV(SD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    typedef struct {
        logic [4:0] letter;
        logic [3:0] sel;
        logic       busy;
        logic       wrap;
    } exp_t;

    typedef struct {
        logic       start;
        logic       stop;
        logic       wr_en;
        logic [3:0] addr;
        logic [4:0] data;
        logic [4:0] len;
        logic [4:0] e_letter;
        logic [3:0] e_sel;
        logic       e_busy;
        logic       e_wrap;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[14];
    int   checks = 0;
    int   failures = 0;

    // Reference model state
    logic [4:0] mbuf[ML];
    bit         m_run;
    int         m_t;
    int         m_len;
    int         wrap_seen;
    int         twelve_seen;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected outputs for the current model cycle, derived from time in RUN.
    function automatic exp_t model_expect();
        exp_t e;
        int d;
        int off;
        int p;
        logic [3:0] one;
        one = 4'b0001;
        e.letter = 5'd31;
        e.sel    = 4'b1111;
        e.busy   = 1'b0;
        e.wrap   = 1'b0;
        if (m_run) begin
            d      = (m_t / MD) % ND;
            off    = (m_len > ND) ? ((m_t / (MD * ND * SD)) % m_len) : 0;
            e.busy = 1'b1;
            e.sel  = ~(one << d);
            e.wrap = (m_len > ND) && (m_t != 0) && ((m_t % (MD * ND * SD * m_len)) == 0);
            if (d >= m_len) begin
                e.letter = 5'd31;
            end else begin
                p = (off + d) % m_len;
                e.letter = mbuf[p];
                if (e.letter > 5'd15) e.letter = 5'd31;
            end
        end
        return e;
    endfunction

    task automatic check_now(input string name, input exp_t e);
        checks++;
        if (bif.letter !== e.letter || bif.digit_sel_n !== e.sel ||
            bif.busy !== e.busy || bif.wrap !== e.wrap) begin
            failures++;
            $display("FAIL %s: got letter=%0d sel=%b busy=%b wrap=%b, want letter=%0d sel=%b busy=%b wrap=%b",
                     name, bif.letter, bif.digit_sel_n, bif.busy, bif.wrap,
                     e.letter, e.sel, e.busy, e.wrap);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // One clock: drive inputs, queue the model's expectation, compare after the edge.
    task automatic cycle(input logic st, input logic sp, input logic we,
                         input logic [3:0] wa, input logic [4:0] wd, input logic [4:0] ml);
        exp_t e;
        bif.start   = st;
        bif.stop    = sp;
        bif.wr_en   = we;
        bif.wr_addr = wa;
        bif.wr_data = wd;
        bif.msg_len = ml;
        if (!m_run) begin
            if (!sp && st && ml >= 5'd1 && ml <= 5'd16) begin
                m_run = 1'b1;
                m_t   = 0;
                m_len = int'(ml);
            end
        end else if (sp) begin
            m_run = 1'b0;
        end else begin
            m_t++;
        end
        sb_q.push_back(model_expect());
        if (we) mbuf[wa] = wd;
        @(negedge clk);
        bif.start = 1'b0;
        bif.stop  = 1'b0;
        bif.wr_en = 1'b0;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard: queue empty at t=%0d", m_t);
        end else begin
            e = sb_q.pop_front();
            check_now($sformatf("cycle_t%0d", m_t), e);
        end
        if (bif.wrap === 1'b1) wrap_seen++;
        if (bif.busy === 1'b1 && bif.letter === 5'd12) twelve_seen++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 5'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        bif.start   = 1'b0;
        bif.stop    = 1'b0;
        bif.wr_en   = 1'b0;
        bif.wr_addr = 4'd0;
        bif.wr_data = 5'd0;
        bif.msg_len = 5'd0;
        m_run       = 1'b0;
        m_t         = 0;
        m_len       = 0;
        wrap_seen   = 0;
        twelve_seen = 0;
        for (int i = 0; i < ML; i++) mbuf[i] = 5'd31;

        // Control corners in IDLE, load 0..5, start with length 6, first digit steps.
        vecs[0] = '{1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 5'd0,  5'd31, 4'b1111, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 5'd17, 5'd31, 4'b1111, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 4'd0, 5'd0, 5'd6,  5'd31, 4'b1111, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            vecs[3+i] = '{1'b0, 1'b0, 1'b1, 4'(i), 5'(i), 5'd0, 5'd31, 4'b1111, 1'b0, 1'b0};
        end
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 5'd6, 5'd0, 4'b1110, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 5'd6, 5'd0, 4'b1110, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 5'd6, 5'd0, 4'b1110, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 5'd6, 5'd0, 4'b1110, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 5'd6, 5'd1, 4'b1101, 1'b1, 1'b0};

        #12;
        check_now("reset", '{5'd31, 4'b1111, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            cycle(vecs[i].start, vecs[i].stop, vecs[i].wr_en, vecs[i].addr, vecs[i].data, vecs[i].len);
            check_now($sformatf("vec%0d", i),
                      '{vecs[i].e_letter, vecs[i].e_sel, vecs[i].e_busy, vecs[i].e_wrap});
        end

        // Mux cadence and scrolling through one full wrap (t = 192).
        wrap_seen = 0;
        run(196);
        check_int("wrap_once", wrap_seen, 1);
        cycle(1'b0, 1'b1, 1'b0, 4'd0, 5'd0, 5'd0);
        check_int("stop_busy", int'(bif.busy), 0);

        // Short static message: 7, 9, blank, blank; never wraps.
        cycle(1'b0, 1'b0, 1'b1, 4'd0, 5'd7, 5'd0);
        cycle(1'b0, 1'b0, 1'b1, 4'd1, 5'd9, 5'd0);
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 5'd2);
        check_now("short_first", '{5'd7, 4'b1110, 1'b1, 1'b0});
        wrap_seen = 0;
        run(500);
        check_int("short_no_wrap", wrap_seen, 0);
        cycle(1'b0, 1'b1, 1'b0, 4'd0, 5'd0, 5'd0);

        // Full-length message boundary.
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 5'd16);
        run(40);
        cycle(1'b0, 1'b1, 1'b0, 4'd0, 5'd0, 5'd0);

        // Restart with 6 letters; start in RUN ignored; write during RUN.
        cycle(1'b0, 1'b0, 1'b1, 4'd0, 5'd0, 5'd0);
        cycle(1'b0, 1'b0, 1'b1, 4'd1, 5'd1, 5'd0);
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 5'd6);
        run(10);
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 5'd3);
        run(40);
        twelve_seen = 0;
        cycle(1'b0, 1'b0, 1'b1, 4'd1, 5'd12, 5'd0);
        run(100);
        check_int("write_in_run_seen", (twelve_seen > 0) ? 1 : 0, 1);
        cycle(1'b1, 1'b1, 1'b0, 4'd0, 5'd0, 5'd6);
        check_int("start_stop_idle", int'(bif.busy), 0);

        // Asynchronous reset mid-digit clears outputs and buffer.
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 5'd6);
        run(5);
        #2;
        rst_n = 1'b0;
        #1;
        check_now("async_reset", '{5'd31, 4'b1111, 1'b0, 1'b0});
        m_run = 1'b0;
        for (int i = 0; i < ML; i++) mbuf[i] = 5'd31;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 5'd6);
        check_now("after_reset_blank", '{5'd31, 4'b1110, 1'b1, 1'b0});
        run(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
